// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Output-side bundle of the UART receive stage: the received byte on a
//   valid/ready handshake plus the three one-cycle error pulses.
//   master : the receiver (drives data, valid and error pulses; reads ready)
//   slave  : the byte consumer (reads data, valid and errors; drives ready)
interface uart_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_error;
  logic       overrun;
  logic       parity_error;

  modport master (
    output rx_data,
    output rx_valid,
    output framing_error,
    output overrun,
    output parity_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  framing_error,
    input  overrun,
    input  parity_error,
    output rx_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampling UART receive stage. Recovers 8-bit frames LSB-first from an
//   asynchronous serial line and presents them on a valid/ready handshake.
//   Optional even-parity bit between data and stop when RX_PARITY_EN is
//   defined; otherwise 8N1 and parity_error is tied low.
// Ports
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous active-high reset
//   uart_in  : asynchronous serial line, idles high
//   rx       : uart_receiver_if.master -- rx_data/rx_valid/rx_ready handshake,
//              framing_error/overrun/parity_error one-cycle pulses
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for a synchronised 1->0 edge
// S_START | half a bit in, confirm the start bit is still low
// S_DATA  | sample 8 data bits at bit centres, LSB first
// S_PARITY| sample the even-parity bit (RX_PARITY_EN builds only)
// S_STOP  | sample stop bit: high delivers the byte, low is a framing error
// S_BREAK | line stuck low after a framing error, wait for it to go high
module uart_receiver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            uart_in,
  uart_receiver_if.master rx
);

  localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] FULL_LAST = SAMP_W'(OVERSAMPLE - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_receiver: CLK_HZ/(BAUD*OVERSAMPLE) must be >= 1");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_receiver: OVERSAMPLE must be even and >= 4");
    end
  endgenerate

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;
`endif

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic               line_prev_q;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
`ifdef RX_PARITY_EN
  logic               par_bit_q, par_bit_d;
  logic               perr_q, perr_d;
`endif

  logic line;
  logic tick;
  logic stop_sample;

  assign line = sync2_q;
  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    samp_cnt_d  = samp_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;
    stop_sample = 1'b0;
`ifdef RX_PARITY_EN
    par_bit_d   = par_bit_q;
    perr_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        samp_cnt_d = '0;
        if (line_prev_q && !line) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (samp_cnt_q == HALF_LAST) begin
            samp_cnt_d = '0;
            bit_idx_d  = '0;
            // A start bit that is high again by mid-bit was a glitch.
            state_d    = line ? S_IDLE : S_DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (samp_cnt_q == FULL_LAST) begin
            samp_cnt_d = '0;
            shift_d    = {line, shift_q[7:1]};
            bit_idx_d  = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end

`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (samp_cnt_q == FULL_LAST) begin
            samp_cnt_d = '0;
            par_bit_d  = line;
            state_d    = S_STOP;
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          if (samp_cnt_q == FULL_LAST) begin
            samp_cnt_d  = '0;
            stop_sample = 1'b1;
            state_d     = line ? S_IDLE : S_BREAK;
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end

      S_BREAK: begin
        samp_cnt_d = '0;
        if (line) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        samp_cnt_d = '0;
      end
    endcase

    // Output register: a completed byte takes priority over a plain accept;
    // if the consumer is taking the old byte in the same cycle, the new one
    // simply replaces it.
    if (stop_sample && line) begin
      if (!rx_valid_q || rx.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (stop_sample && !line) begin
      ferr_d = 1'b1;
    end

`ifdef RX_PARITY_EN
    // Even parity: data bits plus parity bit carry an even number of ones.
    if (stop_sample) begin
      perr_d = par_bit_q ^ (^shift_q);
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      tick_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= uart_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      tick_cnt_q  <= tick_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
`ifdef RX_PARITY_EN
      par_bit_q   <= par_bit_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx.rx_data       = rx_data_q;
  assign rx.rx_valid      = rx_valid_q;
  assign rx.framing_error = ferr_q;
  assign rx.overrun       = ovr_q;
`ifdef RX_PARITY_EN
  assign rx.parity_error  = perr_q;
`else
  assign rx.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks per bit (DIV=1).
module tb_uart_receiver;
  localparam int BIT_CLKS = 16;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Start edge driven -> rx_valid visible: 2 sync + edge detect + 8 start
  // ticks + 8 data bits + (parity) + 16 stop ticks, measured in cycles.
  localparam int LAT = PAR_EN ? 171 : 155;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_in = 1'b1;

  uart_receiver_if rx_if ();

  uart_receiver #(.CLK_HZ(160), .BAUD(10), .OVERSAMPLE(16)) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .uart_in (uart_in),
    .rx      (rx_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts error pulses and collects accepted bytes.
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, acc_cnt = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic [7:0] mon_q[$];

  always @(negedge clk) begin
    if (rx_if.framing_error === 1'b1) fe_cnt++;
    if (rx_if.overrun === 1'b1) ov_cnt++;
    if (rx_if.parity_error === 1'b1) pe_cnt++;
    if (rx_if.rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
      acc_cnt++;
      mon_q.push_back(rx_if.rx_data);
    end
    prev_valid = rx_if.rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_in = b;
    wait_clks(BIT_CLKS);
  endtask

  int start_cyc = 0;

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip,
                            input int extra_low);
    uart_in = 1'b0;
    start_cyc = cyc;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ par_flip);
    send_bit(stop);
    if (!stop) repeat (extra_low) send_bit(1'b0);
    uart_in = 1'b1;
    wait_clks(2 * BIT_CLKS);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         ready;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
    int         exp_acc;
  } vec_t;

  vec_t vecs[5];
  int s_fe, s_ov, s_pe, s_acc;

  task automatic snap();
    s_fe = fe_cnt; s_ov = ov_cnt; s_pe = pe_cnt; s_acc = acc_cnt;
  endtask

  // Reference model state for the randomized phase.
  bit         m_valid;
  logic [7:0] m_data;
  logic [7:0] exp_q[$];

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 0, 0, 1};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 1, 0};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 0, 1};
    vecs[4] = '{8'h42, 1'b1, 1'b1, 1'b0, 8'h42, 0, 0, 1};

    rx_if.rx_ready = 1'b0;
    #2 rst = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(4);
    check("reset rx_valid", rx_if.rx_valid, 0);
    check("reset rx_data", rx_if.rx_data, 0);
    check("reset framing_error", rx_if.framing_error, 0);
    check("reset overrun", rx_if.overrun, 0);
    check("reset parity_error", rx_if.parity_error, 0);

    for (int i = 0; i < 5; i++) begin
      snap();
      rx_if.rx_ready = vecs[i].ready;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, 2);
      check($sformatf("vec%0d rx_valid", i), rx_if.rx_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d rx_data", i), rx_if.rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d framing_error", i), fe_cnt - s_fe, vecs[i].exp_fe);
      check($sformatf("vec%0d overrun", i), ov_cnt - s_ov, vecs[i].exp_ov);
      check($sformatf("vec%0d parity_error", i), pe_cnt - s_pe, 0);
      check($sformatf("vec%0d accepted", i), acc_cnt - s_acc, vecs[i].exp_acc);
      if (i == 0) check("delivery latency", rise_cyc - start_cyc, LAT);
    end

    // Short low glitch on an idle line, then a normal frame.
    rx_if.rx_ready = 1'b1;
    snap();
    uart_in = 1'b0;
    wait_clks(4);
    uart_in = 1'b1;
    wait_clks(3 * BIT_CLKS);
    check("glitch rx_valid", rx_if.rx_valid, 0);
    check("glitch accepted", acc_cnt - s_acc, 0);
    check("glitch errors", (fe_cnt - s_fe) + (ov_cnt - s_ov) + (pe_cnt - s_pe), 0);
    send_frame(8'h99, 1'b1, 1'b0, 0);
    check("post-glitch accepted", acc_cnt - s_acc, 1);
    check("post-glitch data", mon_q[$], 8'h99);

    // Reset in the middle of bit 4 of 0xFF, then 0x0F.
    snap();
    uart_in = 1'b0;
    wait_clks(BIT_CLKS);
    uart_in = 1'b1;
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    send_frame(8'h0F, 1'b1, 1'b0, 0);
    check("reset-abort accepted", acc_cnt - s_acc, 1);
    check("reset-abort data", mon_q[$], 8'h0F);
    check("reset-abort framing", fe_cnt - s_fe, 0);

`ifdef RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("bad parity pulse", pe_cnt - s_pe, 1);
    check("bad parity data", mon_q[$], 8'h07);
    check("bad parity accepted", acc_cnt - s_acc, 1);
    snap();
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("good parity pulse", pe_cnt - s_pe, 0);
    check("good parity accepted", acc_cnt - s_acc, 1);
`endif

    // Randomized frames against a transaction-level model.
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    m_valid = 1'b0;
    m_data  = 8'h00;
    mon_q.delete();
    exp_q.delete();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit r, stop, pf;
      int efe, eov, epe;
      d    = 8'($urandom_range(0, 255));
      r    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 7) != 0);
      pf   = PAR_EN && ($urandom_range(0, 3) == 0);
      efe = 0; eov = 0; epe = pf ? 1 : 0;
      if (m_valid && r) begin
        exp_q.push_back(m_data);
        m_valid = 1'b0;
      end
      if (!stop) efe = 1;
      else if (m_valid) eov = 1;
      else begin
        m_valid = 1'b1;
        m_data  = d;
        if (r) begin
          exp_q.push_back(d);
          m_valid = 1'b0;
        end
      end
      snap();
      rx_if.rx_ready = r;
      send_frame(d, stop, pf, $urandom_range(0, 3));
      check($sformatf("rnd%0d rx_valid", n), rx_if.rx_valid, m_valid);
      check($sformatf("rnd%0d rx_data", n), rx_if.rx_data, m_data);
      check($sformatf("rnd%0d framing_error", n), fe_cnt - s_fe, efe);
      check($sformatf("rnd%0d overrun", n), ov_cnt - s_ov, eov);
      check($sformatf("rnd%0d parity_error", n), pe_cnt - s_pe, epe);
    end
    check("rnd accepted count", mon_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++)
      check($sformatf("rnd accepted byte %0d", k), mon_q[k], exp_q[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
